// File: rtl/aes128_type_pkg.sv
// aes128_type_pkg: shared AES types, MixColumns coefficient rows and GF(2^8) helper
package aes128_type_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, MUL, DONE} mc_state_t;
  localparam logic [31:0] MIXCOL_FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [31:0] MIXCOL_INV_COEF = {8'h0E, 8'h0B, 8'h0D, 8'h09};
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes128_gmul.sv
// aes128_gmul: bit-serial GF(2^8) multiplier, two cycles per significant coefficient bit
module aes128_gmul
  import aes128_type_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] result_o,
  output logic       valid_o
);
  logic       busy;
  logic [3:0] cnt;
  logic [3:0] idx;
  logic [3:0] nbits;
  logic [7:0] x;
  // coefficient width sets latency: 1 bit -> 2, 2 bits -> 4, 4 bits -> 8, 8 bits -> 16
  always_comb nbits = |a_i[7:4] ? 4'd8 : |a_i[3:2] ? 4'd4 : a_i[1] ? 4'd2 : 4'd1;
  // a_i is read live on every busy cycle, so the caller must hold it stable
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy     <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      x        <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!busy) begin
        if (start_i) begin
          busy     <= 1'b1;
          cnt      <= {nbits[2:0], 1'b0} - 4'd1;
          idx      <= '0;
          x        <= b_i;
          result_o <= '0;
        end
      end else begin
        if (idx < nbits) begin
          result_o <= result_o ^ (a_i[idx[2:0]] ? x : 8'h00);
          x        <= xtime(x);
          idx      <= idx + 4'd1;
        end
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          busy    <= 1'b0;
          valid_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/aes128_mixcolumn.sv
// aes128_mixcolumn: serial (Inv)MixColumns of one column through a shared GF multiplier
module aes128_mixcolumn
  import aes128_type_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        inv_i,
  input  logic [31:0] col_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] col_o
);
  mc_state_t   state, state_nxt;
  logic [31:0] cap;
  logic        inv;
  logic [7:0]  acc;
  logic [1:0]  r, c;
  logic        mul_start, mul_valid;
  logic [7:0]  mul_a, mul_b, mul_result;

  function automatic logic [7:0] coef(input logic sel_inv, input logic [1:0] row, input logic [1:0] cl);
    logic [1:0]  k;
    logic [31:0] base;
    k    = cl - row;
    base = (sel_inv ? MIXCOL_INV_COEF : MIXCOL_FWD_COEF) << {k, 3'b000};
    return base[31:24];
  endfunction

  assign mul_a = coef(inv, r, c);
  assign mul_b = cap[{c, 3'b000} +: 8];

  aes128_gmul u_gmul (
    .clk_i    (clk_i),
    .rst_n_i  (~rst_i),
    .start_i  (mul_start),
    .a_i      (mul_a),
    .b_i      (mul_b),
    .result_o (mul_result),
    .valid_o  (mul_valid)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt = state == IDLE  ? (start_i ? ISSUE : IDLE) :
                state == ISSUE ? MUL :
                state == MUL   ? (mul_valid ? ((c == 2'd3 && r == 2'd3) ? DONE : ISSUE) : MUL) :
                IDLE;
    mul_start = state == ISSUE;
    ready_o   = state == IDLE;
    valid_o   = state == DONE;
  end

  // capture the column, then fold each product into the current row's accumulator
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap   <= '0;
      inv   <= 1'b0;
      acc   <= '0;
      r     <= '0;
      c     <= '0;
      col_o <= '0;
    end else if (state == IDLE && start_i) begin
      cap <= col_i;
      inv <= inv_i;
      acc <= '0;
      r   <= '0;
      c   <= '0;
    end else if (state == MUL && mul_valid) begin
      if (c == 2'd3) begin
        col_o[{r, 3'b000} +: 8] <= acc ^ mul_result;
        acc <= '0;
        c   <= '0;
        r   <= r + 2'd1;
      end else begin
        acc <= acc ^ mul_result;
        c   <= c + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_aes128_mixcolumn.sv
// tb_aes128_mixcolumn: directed and round-trip checks of the serial MixColumns unit
module tb_aes128_mixcolumn;
  import aes128_type_pkg::*;

  typedef struct {
    logic [31:0] c;
    logic        i;
    logic [31:0] e;
    int          l;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, inv, ready, valid;
  logic [31:0] col_in, col_out;
  int          errors = 0, checks = 0, viol = 0;

  always #5 clk = ~clk;

  aes128_mixcolumn dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .inv_i   (inv),
    .col_i   (col_in),
    .ready_o (ready),
    .valid_o (valid),
    .col_o   (col_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] c_in, input logic inv_in, output logic [31:0] res, output int lat);
    @(negedge clk);
    check("ready_idle", 32'(ready), 32'd1);
    start  = 1'b1;
    col_in = c_in;
    inv    = inv_in;
    @(posedge clk);
    lat = 0;
    res = 'x;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) begin
        lat = n;
        res = col_out;
        break;
      end
    end
  endtask

  mc_state_t  prev_state = IDLE;
  logic [7:0] pa = '0, pb = '0;
  logic       mon_busy = 1'b0;

  // multiplier handshake and operand stability monitor
  always @(negedge clk) begin
    if (rst) mon_busy = 1'b0;
    else begin
      if (dut.mul_start && mon_busy) viol++;
      if (dut.state == MUL && (prev_state == ISSUE || prev_state == MUL) &&
          (dut.mul_a !== pa || dut.mul_b !== pb)) viol++;
      if (dut.mul_start) mon_busy = 1'b1;
      if (dut.mul_valid) mon_busy = 1'b0;
    end
    prev_state = dut.state;
    pa = dut.mul_a;
    pb = dut.mul_b;
  end

  vec_t        vecs[5];
  logic [31:0] res, x, y, z;
  int          lat, pulses, first, busy_ready;

  initial begin
    vecs = '{'{32'h455313db, 1'b0, 32'hbca14d8e, 65},
             '{32'h5c220af2, 1'b0, 32'h9d58dc9f, 65},
             '{32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6, 65},
             '{32'hd5d4d4d4, 1'b0, 32'hd6d7d5d5, 65},
             '{32'hbca14d8e, 1'b1, 32'h455313db, 145}};
    rst = 1'b1; start = 1'b0; inv = 1'b0; col_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_col", col_out, 32'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      run_op(vecs[k].c, vecs[k].i, res, lat);
      check("vec_result", res, vecs[k].e);
      check("vec_latency", 32'(lat), 32'(vecs[k].l));
    end

    @(negedge clk);
    start = 1'b1; col_in = 32'h455313db; inv = 1'b0;
    @(posedge clk);
    pulses = 0; first = 0; busy_ready = 0;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      start = (n < 40) || (n >= 42 && n < 60);
      if (valid) begin
        pulses++;
        if (first == 0) first = n;
        res = col_out;
      end
      if (n <= 65 && ready) busy_ready++;
    end
    start = 1'b0;
    check("held_pulses", 32'(pulses), 32'd1);
    check("held_latency", 32'(first), 32'd65);
    check("held_busy_ready", 32'(busy_ready), 32'd0);
    check("held_result", res, 32'hbca14d8e);
    check("held_ready_after", 32'(ready), 32'd1);

    @(negedge clk);
    start = 1'b1; col_in = 32'h455313db; inv = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("partial_row0", {24'd0, col_out[7:0]}, 32'h0000008e);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_col", col_out, 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    run_op(32'h01010101, 1'b0, res, lat);
    check("post_abort_result", res, 32'h01010101);
    check("post_abort_latency", 32'(lat), 32'd65);

    for (int i = 0; i < 150; i++) begin
      x = $urandom;
      run_op(x, 1'b0, y, lat);
      run_op(y, 1'b1, z, lat);
      check("roundtrip", z, x);
    end

    check("protocol_viol", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
